csdf_flux_sched: RTL
====================

CSDF_FLUX_SCHED -- requirements
Module: csdf_flux_sched

Interface
REQ-001 SHALL have parameter FLUX, default 2, meaning number of tagged fluxes sharing one CSDF actor.
REQ-002 SHALL have parameter NUM_OP, default 4, meaning tokens consumed per firing; a value of 0 is treated as 1.
REQ-003 SHALL have parameter WDOG_CYCLES, default 64, meaning the idle-grant timeout; it is used only when CSDF_SCHED_WDOG_EN is defined.
REQ-004 SHALL derive localparam TAG_WIDTH = max(1, $clog2(FLUX)) and CNT_WIDTH = max(1, $clog2(NUM_OP)).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port req, input, FLUX bits: bit f = flux f has a token on every input port (not empty).
REQ-008 SHALL have port full, input, 1 bit: the actor's output FIFO is full.
REQ-009 SHALL have port consume, input, 1 bit: the actor read the granted flux this cycle.
REQ-010 SHALL have port fire_done, input, 1 bit: the actor wrote one firing result this cycle.
REQ-011 SHALL have port grant, output, FLUX bits: one-hot grant, all zero when idle.
REQ-012 SHALL have port grant_tag, output, TAG_WIDTH bits: index of the granted flux.
REQ-013 SHALL have port grant_valid, output, 1 bit: a grant is active.
REQ-014 SHALL have port op_cnt, output, CNT_WIDTH bits: tokens consumed in the current firing.
REQ-015 SHALL have port err, output, 1 bit: sticky protocol or watchdog error.

Function
REQ-016 SHALL implement a three-state FSM (IDLE, RUN, WAIT_OUT) with all outputs registered.
REQ-017 In IDLE with any req bit set, SHALL grant the first requesting flux, searching round-robin from last_tag+1 and wrapping modulo FLUX; the grant is visible the next cycle (1-cycle latency) and the FSM enters RUN.
REQ-018 SHALL update last_tag to the granted index at grant time; a flux just served has lowest priority at the next arbitration.
REQ-019 grant, grant_tag and grant_valid SHALL remain stable from grant until release, regardless of req changes.
REQ-020 In RUN, consume SHALL increment op_cnt; consume with grant_valid=0 SHALL be ignored.
REQ-021 A consume while op_cnt = NUM_OP-1 SHALL clear op_cnt to 0; the FSM goes to IDLE if fire_done is asserted in the same cycle, otherwise to WAIT_OUT.
REQ-022 In WAIT_OUT, the FSM SHALL hold the grant while full=1 and, on fire_done, go to IDLE with the grant dropped the next cycle.
REQ-023 fire_done in RUN before the last consume SHALL set err, clear op_cnt and return the FSM to IDLE.
REQ-024 fire_done in IDLE SHALL set err and change no other state.
REQ-025 consume in WAIT_OUT SHALL set err and leave op_cnt unchanged.
REQ-026 With FLUX=1, the arbiter SHALL always grant flux 0.
REQ-027 The FSM SHALL spend at least one IDLE cycle between consecutive grants.
REQ-028 err SHALL clear only on reset.

Reset
REQ-029 rst=0 SHALL asynchronously force state=IDLE, grant=0, grant_tag=0, grant_valid=0, op_cnt=0, err=0 and last_tag=FLUX-1, so flux 0 wins the first arbitration.
REQ-030 Reset asserted mid-firing SHALL abandon the firing, with no partial count retained after release.
REQ-031 Reset deassertion SHALL be used synchronously, and the first arbitration SHALL occur no earlier than the first rising edge after release.

Configuration
REQ-032 When macro CSDF_SCHED_WDOG_EN is defined, SHALL count consecutive RUN cycles without consume; on reaching WDOG_CYCLES it SHALL set err, clear op_cnt and return to IDLE.
REQ-033 The watchdog count SHALL reset on each consume and on every state exit, and SHALL not count in WAIT_OUT.
REQ-034 When CSDF_SCHED_WDOG_EN is undefined, SHALL include no watchdog logic, SHALL ignore WDOG_CYCLES, and RUN SHALL wait indefinitely.

Verification
REQ-035 Bench SHALL cover: reset released, req=2'b11, FLUX=2, NUM_OP=4 -> grant=01 one cycle later; after 4 consumes plus fire_done -> IDLE, then grant=10.
REQ-036 Bench SHALL cover: 4th consume while full=1 and no fire_done -> WAIT_OUT with grant held for 5 full cycles; full=0 with fire_done -> grant=0 the next cycle.
REQ-037 Bench SHALL cover: fire_done after 2 consumes -> err=1, op_cnt=0, IDLE; err still 1 after 10 further normal firings.
REQ-038 Bench SHALL cover: rst=0 asynchronously with op_cnt=3 -> all outputs 0 without a clock edge; after release with req=2'b10 -> grant=10.
REQ-039 Bench SHALL cover: CSDF_SCHED_WDOG_EN defined, WDOG_CYCLES=8, grant then no consume -> err=1 and grant=0 after 8 cycles; same stimulus with the macro undefined -> grant held and err=0 after 100 cycles.
REQ-040 Bench SHALL cover: FLUX=3, req held at 3'b111 for 6 firings -> grant order 0,1,2,0,1,2.

Source files
------------

// File: rtl/csdf_flux_sched.sv
// Round-robin flux scheduler for a shared CSDF actor: grants one tagged flux per firing,
// counts consumed tokens and flags protocol misuse. Optional idle watchdog: CSDF_SCHED_WDOG_EN.
module csdf_flux_sched #(
  parameter  int FLUX        = 2,
  parameter  int NUM_OP      = 4,
  parameter  int WDOG_CYCLES = 64,
  localparam int TAG_WIDTH   = (FLUX > 1) ? $clog2(FLUX) : 1,
  localparam int CNT_WIDTH   = (NUM_OP > 1) ? $clog2(NUM_OP) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLUX-1:0]      req,
  input  logic                 full,
  input  logic                 consume,
  input  logic                 fire_done,
  output logic [FLUX-1:0]      grant,
  output logic [TAG_WIDTH-1:0] grant_tag,
  output logic                 grant_valid,
  output logic [CNT_WIDTH-1:0] op_cnt,
  output logic                 err
);

  localparam int NOP = (NUM_OP < 1) ? 1 : NUM_OP;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(NOP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WAIT_OUT} state_t;

  state_t               r_state, w_state_nxt;
  logic [FLUX-1:0]      r_grant, w_grant_nxt;
  logic [TAG_WIDTH-1:0] r_tag, w_tag_nxt;
  logic                 r_valid, w_valid_nxt;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                 r_err, w_err_nxt;
  logic [TAG_WIDTH-1:0] r_last_tag, w_last_nxt;
  logic                 w_found, w_drop;
  logic [TAG_WIDTH-1:0] w_pick, w_cand;
  logic                 w_unused;

  // full only matters to the actor; the grant is held through WAIT_OUT regardless
  assign w_unused = full;

`ifdef CSDF_SCHED_WDOG_EN
  localparam int WDOG_LIM = (WDOG_CYCLES < 1) ? 1 : WDOG_CYCLES;
  localparam int WDOG_W   = (WDOG_LIM > 1) ? $clog2(WDOG_LIM) : 1;
  logic [WDOG_W-1:0] r_wdog, w_wdog_nxt;
`else
  if (WDOG_CYCLES < 1) begin : g_wdog_ignored
  end
`endif

  // Scan from last_tag+1 downwards in priority so the nearest requester wins
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last_tag;
    w_cand  = '0;
    for (int k = FLUX; k >= 1; k--) begin
      w_cand = TAG_WIDTH'((int'(r_last_tag) + k) % FLUX);
      if (req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_tag_nxt   = r_tag;
    w_valid_nxt = r_valid;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_last_nxt  = r_last_tag;
    w_drop      = 1'b0;
`ifdef CSDF_SCHED_WDOG_EN
    w_wdog_nxt  = '0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (fire_done) begin
          w_err_nxt = 1'b1;
        end else if (w_found) begin
          w_state_nxt = ST_RUN;
          w_grant_nxt = FLUX'(1) << w_pick;
          w_tag_nxt   = w_pick;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_last_nxt  = w_pick;
        end
      end
      ST_RUN: begin
        if (consume) begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt = '0;
            if (fire_done) w_drop = 1'b1;
            else           w_state_nxt = ST_WAIT_OUT;
          end else if (fire_done) begin
            w_err_nxt = 1'b1;
            w_drop    = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
          end
        end else if (fire_done) begin
          w_err_nxt = 1'b1;
          w_drop    = 1'b1;
        end
`ifdef CSDF_SCHED_WDOG_EN
        else if (r_wdog == WDOG_W'(WDOG_LIM - 1)) begin
          w_err_nxt = 1'b1;
          w_drop    = 1'b1;
        end else begin
          w_wdog_nxt = r_wdog + WDOG_W'(1);
        end
`endif
      end
      ST_WAIT_OUT: begin
        if (consume)   w_err_nxt = 1'b1;
        if (fire_done) w_drop    = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_drop) begin
      w_state_nxt = ST_IDLE;
      w_grant_nxt = '0;
      w_tag_nxt   = '0;
      w_valid_nxt = 1'b0;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_tag      <= '0;
      r_valid    <= 1'b0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_last_tag <= TAG_WIDTH'(FLUX - 1);
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_tag      <= w_tag_nxt;
      r_valid    <= w_valid_nxt;
      r_cnt      <= w_cnt_nxt;
      r_err      <= w_err_nxt;
      r_last_tag <= w_last_nxt;
    end
  end

`ifdef CSDF_SCHED_WDOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wdog <= '0;
    else      r_wdog <= w_wdog_nxt;
  end
`endif

  assign grant       = r_grant;
  assign grant_tag   = r_tag;
  assign grant_valid = r_valid;
  assign op_cnt      = r_cnt;
  assign err         = r_err;

endmodule
